bias_loader: RTL

BIAS_LOADER -- requirements
Module: bias_loader

---
 rtl/bias_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bias_loader.sv
// Bias loader: fetches one signed bias word per output channel and presents it to the bias buffer.
// Optional macro BIAS_LOADER_PREFETCH_EN prefetches the next channel's bias during HOLD.
module bias_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CH_WIDTH   = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CH_WIDTH-1:0]          num_ch,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic                         ch_done,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic signed [DATA_WIDTH-1:0] mem_rd_data,
  output logic signed [DATA_WIDTH-1:0] bias_out,
  output logic                         valid_read,
  output logic [CH_WIDTH-1:0]          ch_idx,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_LOAD, S_HOLD, S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [CH_WIDTH-1:0]           num_ch_q, num_ch_d;
  logic [ADDR_WIDTH-1:0]         base_q, base_d;
  logic [CH_WIDTH-1:0]           ch_idx_q, ch_idx_d;
  logic signed [DATA_WIDTH-1:0]  bias_q, bias_d;
  logic                          last_ch;

`ifdef BIAS_LOADER_PREFETCH_EN
  logic signed [DATA_WIDTH-1:0]  pf_q, pf_d;
  logic                          hold_first_q, hold_first_d;
  logic                          pf_wait_q, pf_wait_d;
  logic                          pend_q, pend_d;
`endif

  // Address add wraps naturally at ADDR_WIDTH bits.
  function automatic logic [ADDR_WIDTH-1:0] ch_addr(input logic [ADDR_WIDTH-1:0] b,
                                                    input logic [CH_WIDTH-1:0]   c);
    return b + ADDR_WIDTH'(c);
  endfunction

  assign last_ch  = (ch_idx_q == num_ch_q - CH_WIDTH'(1));
  assign bias_out = bias_q;
  assign ch_idx   = ch_idx_q;

  always_comb begin
    state_d    = state_q;
    num_ch_d   = num_ch_q;
    base_d     = base_q;
    ch_idx_d   = ch_idx_q;
    bias_d     = bias_q;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    valid_read = 1'b1;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
`ifdef BIAS_LOADER_PREFETCH_EN
    pf_d         = pf_q;
    hold_first_d = 1'b0;
    pf_wait_d    = 1'b0;
    pend_d       = pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_ch_d = num_ch;
          base_d   = base_addr;
          ch_idx_d = '0;
          state_d  = (num_ch == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        mem_rd_en = 1'b1;
        mem_addr  = ch_addr(base_q, ch_idx_q);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        bias_d  = mem_rd_data;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        valid_read = 1'b0;
        state_d    = S_HOLD;
`ifdef BIAS_LOADER_PREFETCH_EN
        hold_first_d = 1'b1;
        pend_d       = 1'b0;
`endif
      end
      S_HOLD: begin
`ifdef BIAS_LOADER_PREFETCH_EN
        if (hold_first_q && !last_ch) begin
          mem_rd_en = 1'b1;
          mem_addr  = ch_addr(base_q, ch_idx_q + CH_WIDTH'(1));
          pf_wait_d = 1'b1;
        end
        if (pf_wait_q) pf_d = mem_rd_data;
        // A ch_done seen before the prefetch data returns is remembered in pend_q.
        if (ch_done || pend_q) begin
          if (last_ch) begin
            state_d = S_DONE;
          end else if (hold_first_q) begin
            pend_d = 1'b1;
          end else begin
            bias_d   = pf_wait_q ? mem_rd_data : pf_q;
            ch_idx_d = ch_idx_q + CH_WIDTH'(1);
            pend_d   = 1'b0;
            state_d  = S_LOAD;
          end
        end
`else
        if (ch_done) begin
          if (last_ch) begin
            state_d = S_DONE;
          end else begin
            ch_idx_d = ch_idx_q + CH_WIDTH'(1);
            state_d  = S_REQ;
          end
        end
`endif
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      num_ch_q <= '0;
      base_q   <= '0;
      ch_idx_q <= '0;
      bias_q   <= '0;
`ifdef BIAS_LOADER_PREFETCH_EN
      pf_q         <= '0;
      hold_first_q <= 1'b0;
      pf_wait_q    <= 1'b0;
      pend_q       <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      num_ch_q <= num_ch_d;
      base_q   <= base_d;
      ch_idx_q <= ch_idx_d;
      bias_q   <= bias_d;
`ifdef BIAS_LOADER_PREFETCH_EN
      pf_q         <= pf_d;
      hold_first_q <= hold_first_d;
      pf_wait_q    <= pf_wait_d;
      pend_q       <= pend_d;
`endif
    end
  end

endmodule
